memcpy_cmd_splitter: RTL and testbench

//  Sits directly downstream of the action's AXI-Lite register slave. It takes the memcpy
//  job it is given (enable, source and target addresses, byte count) and turns it into

---
 rtl/memcpy_cmd_splitter.sv | 177 +++++++++++++++++
 tb/tb_memcpy_cmd_splitter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memcpy_cmd_splitter.sv
// Splits a memcpy job into paired AXI read/write burst commands that never cross a 4KB page.
// One pair per CALC+ISSUE (2 cycles min); each command side waits on its own ready, next pair after both accepted.
module memcpy_cmd_splitter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int MAX_BEATS  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memcpy_enable,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] tgt_addr,
    input  logic [63:0]           total_bytes,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [7:0]            rd_cmd_len,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [7:0]            wr_cmd_len,
    output logic                  cmd_busy,
    output logic                  cmd_done,
    output logic [15:0]           burst_count
);

    localparam int BPB      = DATA_WIDTH / 8;
    localparam int LOG2_BPB = $clog2(BPB);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_enable_q;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_tgt;
    logic [63:0]           r_rem;
    logic [12:0]           r_beats;
    logic                  r_rd_acc;
    logic                  r_wr_acc;

    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_src_in;
    logic [ADDR_WIDTH-1:0] w_tgt_in;
    logic [63:0]           w_total_in;
    logic [12:0]           w_src_room;
    logic [12:0]           w_tgt_room;
    logic [12:0]           w_src_room_beats;
    logic [12:0]           w_tgt_room_beats;
    logic [63:0]           w_rem_beats;
    logic [12:0]           w_beats;
    logic [7:0]            w_len;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [63:0]           w_step64;
    logic                  w_rd_done;
    logic                  w_wr_done;
    logic                  w_pair_done;
    logic                  w_last;

    // Partial beats are dropped: addresses and length are truncated to whole beats.
    assign w_src_in   = src_addr & ~ADDR_WIDTH'(BPB - 1);
    assign w_tgt_in   = tgt_addr & ~ADDR_WIDTH'(BPB - 1);
    assign w_total_in = total_bytes & ~64'(BPB - 1);

    assign w_start = memcpy_enable & ~r_enable_q & ((r_state == S_IDLE) | (r_state == S_DONE));

    assign w_src_room       = 13'd4096 - {1'b0, r_src[11:0]};
    assign w_tgt_room       = 13'd4096 - {1'b0, r_tgt[11:0]};
    assign w_src_room_beats = w_src_room >> LOG2_BPB;
    assign w_tgt_room_beats = w_tgt_room >> LOG2_BPB;
    assign w_rem_beats      = r_rem >> LOG2_BPB;

    always_comb begin
        w_beats = 13'(MAX_BEATS);
        if (w_src_room_beats < w_beats)
            w_beats = w_src_room_beats;
        if (w_tgt_room_beats < w_beats)
            w_beats = w_tgt_room_beats;
        if (w_rem_beats < 64'(w_beats))
            w_beats = w_rem_beats[12:0];
    end

    assign w_len    = 8'(w_beats - 13'd1);
    assign w_step   = ADDR_WIDTH'(r_beats) << LOG2_BPB;
    assign w_step64 = 64'(r_beats) << LOG2_BPB;
    assign w_last   = (r_rem == w_step64);

    // A side counts as done if accepted earlier in this ISSUE or accepted this cycle.
    assign w_rd_done   = r_rd_acc | (rd_cmd_valid & rd_cmd_ready);
    assign w_wr_done   = r_wr_acc | (wr_cmd_valid & wr_cmd_ready);
    assign w_pair_done = (r_state == S_ISSUE) & w_rd_done & w_wr_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start)
                    w_next_state = (w_total_in == 64'd0) ? S_DONE : S_CALC;
            end
            S_CALC:  w_next_state = S_ISSUE;
            S_ISSUE: begin
                if (w_pair_done)
                    w_next_state = w_last ? S_DONE : S_CALC;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable_q   <= 1'b0;
            r_src        <= '0;
            r_tgt        <= '0;
            r_rem        <= '0;
            r_beats      <= '0;
            r_rd_acc     <= 1'b0;
            r_wr_acc     <= 1'b0;
            rd_cmd_valid <= 1'b0;
            rd_cmd_addr  <= '0;
            rd_cmd_len   <= '0;
            wr_cmd_valid <= 1'b0;
            wr_cmd_addr  <= '0;
            wr_cmd_len   <= '0;
            cmd_busy     <= 1'b0;
            cmd_done     <= 1'b0;
            burst_count  <= '0;
        end else begin
            r_enable_q <= memcpy_enable;
            cmd_busy   <= (w_next_state == S_CALC) || (w_next_state == S_ISSUE);
            cmd_done   <= (w_next_state == S_DONE);

            if (w_start) begin
                r_src       <= w_src_in;
                r_tgt       <= w_tgt_in;
                r_rem       <= w_total_in;
                burst_count <= '0;
            end

            if (r_state == S_CALC) begin
                rd_cmd_addr  <= r_src;
                wr_cmd_addr  <= r_tgt;
                rd_cmd_len   <= w_len;
                wr_cmd_len   <= w_len;
                r_beats      <= w_beats;
                rd_cmd_valid <= 1'b1;
                wr_cmd_valid <= 1'b1;
                r_rd_acc     <= 1'b0;
                r_wr_acc     <= 1'b0;
            end

            if (rd_cmd_valid && rd_cmd_ready) begin
                rd_cmd_valid <= 1'b0;
                r_rd_acc     <= 1'b1;
            end
            if (wr_cmd_valid && wr_cmd_ready) begin
                wr_cmd_valid <= 1'b0;
                r_wr_acc     <= 1'b1;
            end

            if (w_pair_done) begin
                r_src <= r_src + w_step;
                r_tgt <= r_tgt + w_step;
                r_rem <= r_rem - w_step64;
                if (burst_count != 16'hFFFF)
                    burst_count <= burst_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_memcpy_cmd_splitter.sv
// Bench for memcpy_cmd_splitter: job table plus scoreboard of expected read/write commands.
module tb_memcpy_cmd_splitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memcpy_enable;
    logic [63:0] src_addr;
    logic [63:0] tgt_addr;
    logic [63:0] total_bytes;
    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    logic [63:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic        wr_cmd_valid;
    logic        wr_cmd_ready;
    logic [63:0] wr_cmd_addr;
    logic [7:0]  wr_cmd_len;
    logic        cmd_busy;
    logic        cmd_done;
    logic [15:0] burst_count;

    always #5 clk = ~clk;

    memcpy_cmd_splitter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .memcpy_enable (memcpy_enable),
        .src_addr      (src_addr),
        .tgt_addr      (tgt_addr),
        .total_bytes   (total_bytes),
        .rd_cmd_valid  (rd_cmd_valid),
        .rd_cmd_ready  (rd_cmd_ready),
        .rd_cmd_addr   (rd_cmd_addr),
        .rd_cmd_len    (rd_cmd_len),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_len    (wr_cmd_len),
        .cmd_busy      (cmd_busy),
        .cmd_done      (cmd_done),
        .burst_count   (burst_count)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } cmd_t;

    typedef struct {
        logic [63:0] src;
        logic [63:0] tgt;
        logic [63:0] total;
        int          exp_n;
    } job_t;

    cmd_t rd_q[$];
    cmd_t wr_q[$];
    int   errors = 0;
    int   checks = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by the test
    job_t jobs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: 64B beats, 64-beat cap, no burst crossing a 4KB page on either side.
    function automatic int model_push(input logic [63:0] src, input logic [63:0] tgt,
                                      input logic [63:0] total);
        logic [63:0] s, t, rem, b, room;
        int n;
        s = src & ~64'h3F;
        t = tgt & ~64'h3F;
        rem = total & ~64'h3F;
        n = 0;
        while (rem != 0) begin
            b = rem / 64;
            if (b > 64) b = 64;
            room = (64'd4096 - 64'(s[11:0])) / 64;
            if (room < b) b = room;
            room = (64'd4096 - 64'(t[11:0])) / 64;
            if (room < b) b = room;
            rd_q.push_back('{addr: s, len: 8'(b - 1)});
            wr_q.push_back('{addr: t, len: 8'(b - 1)});
            s = s + b * 64;
            t = t + b * 64;
            rem = rem - b * 64;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) begin
            rd_cmd_ready = 1'b1;
            wr_cmd_ready = 1'b1;
        end else if (rdy_mode == 1) begin
            rd_cmd_ready = ($urandom_range(0, 3) != 0);
            wr_cmd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        cmd_t e;
        if (rst_n) begin
            if (rd_cmd_valid && rd_cmd_ready) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got cmd 0x%0h len %0d, expected none", rd_cmd_addr, rd_cmd_len);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_addr", rd_cmd_addr, e.addr);
                    chk("rd_len", 64'(rd_cmd_len), 64'(e.len));
                end
            end
            if (wr_cmd_valid && wr_cmd_ready) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got cmd 0x%0h len %0d, expected none", wr_cmd_addr, wr_cmd_len);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", wr_cmd_addr, e.addr);
                    chk("wr_len", 64'(wr_cmd_len), 64'(e.len));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the job finished.
    task automatic run_job(input job_t j, input bit strict_timing);
        int n, cyc;
        n = model_push(j.src, j.tgt, j.total);
        src_addr = j.src;
        tgt_addr = j.tgt;
        total_bytes = j.total;
        memcpy_enable = 1'b1;
        @(posedge clk); #1;
        memcpy_enable = 1'b0;
        src_addr = {$urandom, $urandom};
        tgt_addr = {$urandom, $urandom};
        total_bytes = {$urandom, $urandom};
        if (n > 0) chk("busy_at_start", cmd_busy, 1);
        cyc = 0;
        while (!cmd_done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) memcpy_enable = 1'b1;   // second edge mid-job must be ignored
        end
        chk("cmd_done", cmd_done, 1);
        if (strict_timing) chk("job_cycles", 64'(cyc), 64'(2 * n));
        chk("burst_count", 64'(burst_count), 64'(j.exp_n));
        chk("busy_end", cmd_busy, 0);
        chk("rd_pending", 64'(rd_q.size()), 0);
        chk("wr_pending", 64'(wr_q.size()), 0);
        memcpy_enable = 1'b0;
        @(posedge clk); #1;
        chk("rd_vld_idle", rd_cmd_valid, 0);
        chk("done_sticky", cmd_done, 1);
    endtask

    initial begin
        int n, cyc;
        jobs[0] = '{64'h1000, 64'h2000, 64'd256, 1};
        jobs[1] = '{64'h0FC0, 64'h3000, 64'd256, 2};
        jobs[2] = '{64'h0, 64'h10000, 64'd8192, 2};
        jobs[3] = '{64'h1000, 64'h2000, 64'h3F, 0};
        jobs[4] = '{64'h1025, 64'h2F80, 64'h2C0, 2};
        jobs[5] = '{64'h0F00, 64'h5E40, 64'h1000, 3};
        jobs[6] = '{64'h0, 64'h20000, 64'h10000, 16};
        jobs[7] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 64'd128, 2};

        rst_n = 1'b0;
        memcpy_enable = 1'b0;
        src_addr = '0;
        tgt_addr = '0;
        total_bytes = '0;
        rd_cmd_ready = 1'b1;
        wr_cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_vld", rd_cmd_valid, 0);
        chk("rst_wr_vld", wr_cmd_valid, 0);
        chk("rst_busy", cmd_busy, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_count", 64'(burst_count), 0);
        chk("rst_rd_addr", rd_cmd_addr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (jobs[i]) run_job(jobs[i], 1'b1);
        rdy_mode = 1;
        foreach (jobs[i]) run_job(jobs[i], 1'b0);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Read side stalls, write side accepted first.
        rdy_mode = 2;
        rd_cmd_ready = 1'b0;
        wr_cmd_ready = 1'b1;
        n = model_push(64'h0FC0, 64'h3000, 64'd256);
        src_addr = 64'h0FC0;
        tgt_addr = 64'h3000;
        total_bytes = 64'd256;
        memcpy_enable = 1'b1;
        @(posedge clk); #1;
        memcpy_enable = 1'b0;
        cyc = 0;
        while (!rd_cmd_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_rd_vld_rise", rd_cmd_valid, 1);
        chk("stall_wr_vld_rise", wr_cmd_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("stall_rd_vld", rd_cmd_valid, 1);
            chk("stall_rd_addr", rd_cmd_addr, 64'h0FC0);
            chk("stall_rd_len", 64'(rd_cmd_len), 0);
            chk("stall_wr_vld", wr_cmd_valid, 0);
            chk("stall_busy", cmd_busy, 1);
        end
        rd_cmd_ready = 1'b1;
        cyc = 0;
        while (!cmd_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_done", cmd_done, 1);
        chk("stall_count", 64'(burst_count), 64'(n));
        chk("stall_rd_pending", 64'(rd_q.size()), 0);
        chk("stall_wr_pending", 64'(wr_q.size()), 0);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Asynchronous reset while commands are pending.
        rdy_mode = 2;
        rd_cmd_ready = 1'b0;
        wr_cmd_ready = 1'b0;
        src_addr = 64'h1000;
        tgt_addr = 64'h2000;
        total_bytes = 64'd256;
        memcpy_enable = 1'b1;
        @(posedge clk); #1;
        memcpy_enable = 1'b0;
        cyc = 0;
        while (!rd_cmd_valid && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("arst_pre_vld", rd_cmd_valid, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_vld", rd_cmd_valid, 0);
        chk("arst_wr_vld", wr_cmd_valid, 0);
        chk("arst_busy", cmd_busy, 0);
        chk("arst_done", cmd_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_q.delete();
        wr_q.delete();
        rdy_mode = 0;
        @(posedge clk); #1;
        run_job(jobs[0], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
